bmem_line_arbiter: RTL
======================

Name: bmem_line_arbiter

Overview:
- Sits between the instruction and data caches and the cpu's banked burst-memory port (bmem_*). It is the stage that directly feeds the banked DRAM controller.
- Arbitrates 256-bit cacheline read/write requests from the two caches onto one 64-bit, 4-beat burst interface.
- Serializes write lines into beats and deserializes read beats into lines.
- Read data returns out of order, tagged by raddr; the block routes each returning burst to the cache that requested it.

Parameters:
- LINE_BITS, 256, cacheline width
- BEAT_BITS, 64, memory beat width
- BEATS, LINE_BITS/BEAT_BITS (=4), beats per burst

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_addr  in  32  icache line request address
- i_read  in  1  icache read request; held until i_resp
- i_rdata  out  256  icache line data
- i_resp  out  1  icache completion pulse
- d_addr  in  32  dcache line request address
- d_read  in  1  dcache read request; held until d_resp
- d_write  in  1  dcache write request; held until d_resp
- d_wdata  in  256  dcache write line
- d_rdata  out  256  dcache line data
- d_resp  out  1  dcache completion pulse
- bmem_addr  out  32  burst address, always 32-byte aligned
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts a command/beat this cycle
- bmem_raddr  in  32  address tag of the returning read beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid
- err  out  1  sticky protocol error

Behaviour:
- Reset (async): all outputs 0; all pending flags, beat counters and the round-robin pointer (initialised to icache) cleared. Reset asserted mid-burst drops bmem_read/bmem_write immediately; no partial response is delivered afterwards.
- bmem_addr = {req_addr[31:5], 5'b0}.
- Issue FSM states:
  - ISSUE_IDLE: choose a candidate among eligible requesters:
    - icache eligible when i_read is high and icache has no read pending.
    - dcache eligible when d_read or d_write is high and dcache has no operation pending.
    - When both are eligible, the round-robin pointer decides; the pointer flips to the other port after each grant.
  - Read grant:
    - Drive bmem_read=1 with the address.
    - On a cycle with bmem_ready=1: set that port's pending flag, store the line address, stay in ISSUE_IDLE.
    - On bmem_ready=0: hold the command unchanged.
  - Write grant: go to WRITE_BURST with the beat counter at 0.
  - WRITE_BURST:
    - Drive bmem_write=1, bmem_addr, and bmem_wdata = d_wdata[64*cnt +: 64].
    - The counter advances only on bmem_ready=1.
    - On acceptance of beat 3: pulse d_resp next cycle, return to ISSUE_IDLE.
    - bmem_read is never asserted during WRITE_BURST.
- Read return path:
  - For each port, a 2-bit beat counter and a 256-bit line buffer.
  - A beat with rvalid=1 and raddr matching a pending port's stored line address is written to slot[cnt]; cnt then increments.
  - On beat 3: in the next cycle, assert x_resp for exactly 1 cycle with x_rdata equal to the full line. Clear pending and the counter.
  - x_rdata holds its value until the next completion.
- Alias hazard: a read whose line address equals the other port's pending read line address is not issued until that read completes. This keeps raddr unambiguous.
- Simultaneous events: a return-beat capture and a new issue in the same cycle are independent and both proceed. Once a port's response pulse has been delivered, a new request from that port is eligible in the following cycle.
- Errors (set err, which is sticky until reset):
  - rvalid with an raddr matching no pending read.
  - d_read and d_write both high.
  - A requester dropping its request before its response.
- Latency (memory ready, no contention):
  - Read: command issued in cycle 0; resp 1 cycle after the final beat.
  - Write: 4 cycles of beats, resp in cycle 4.

Decomposition:
- Shared package bmem_pkg:
  - Constants LINE_BITS, BEAT_BITS, BEATS.
  - Typedef line_t (logic [255:0]) and beat_t.
  - Enum issue_state_t {ISSUE_IDLE, WRITE_BURST}.
- Sub-module line_deserializer, instantiated once per port. It contains the pending flag, stored address, beat counter, line buffer, resp pulse generation and raddr match output.

Test Plan:
- icache read at 0x0000_1040 with memory returning beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x0000_1040, one read command; i_resp 1 cycle after beat 3; i_rdata = {0x44..,0x33..,0x22..,0x11..}.
- dcache write at 0x2000_0000, bmem_ready held low for 2 cycles at beat 1 -> beats emitted in order wdata[63:0]..[255:192]; beat 1 is held for the stall; d_resp asserted once, after beat 3 is accepted.
- icache and dcache reads issued in the same cycle, bursts returned out of order (dcache first) -> icache command first (pointer reset value); each line is routed to the correct port; pointer alternates on the next contention.
- Both ports read line 0x3000_0020 -> the second command is withheld until the first port's resp; no err.
- rvalid with raddr 0xDEAD_0000 and no read pending -> err=1 and stays 1 until rst.
- rst asserted during beat 2 of a write -> bmem_write=0 in the same cycle; no d_resp; after release, the next request starts cleanly from beat 0.

Source files
------------

// File: rtl/bmem_pkg.sv
// Shared types and constants for the cacheline-to-burst memory arbiter.
package bmem_pkg;

    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int BEATS     = LINE_BITS / BEAT_BITS;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0] beat_t;

    typedef enum logic {
        ISSUE_IDLE,
        WRITE_BURST
    } issue_state_t;

    // Burst addresses are always 32-byte aligned.
    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

endpackage

// File: rtl/line_deserializer.sv
// Per-port read return tracker: pending flag, tagged address, beat assembly
// into a line buffer and the one-cycle completion pulse.
module line_deserializer
    import bmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_i,
    input  logic [31:0] issue_addr_i,
    input  logic        rvalid_i,
    input  logic [31:0] raddr_i,
    input  beat_t       rdata_i,
    output logic        pend_o,
    output logic [31:0] addr_o,
    output logic        match_o,
    output line_t       line_o,
    output logic        resp_o
);

    logic        pend_q, pend_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  cnt_q, cnt_d;
    line_t       buf_q, buf_d;
    line_t       line_q, line_d;
    logic        resp_q, resp_d;

    // Pending stays set through the response cycle so the still-held
    // request is not re-issued; beats arriving then are not ours.
    assign match_o = rvalid_i && pend_q && !resp_q && (raddr_i == addr_q);
    assign pend_o  = pend_q;
    assign addr_o  = addr_q;
    assign line_o  = line_q;
    assign resp_o  = resp_q;

    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        buf_d  = buf_q;
        line_d = line_q;
        resp_d = 1'b0;
        if (resp_q) begin
            pend_d = 1'b0;
        end
        if (issue_i) begin
            pend_d = 1'b1;
            addr_d = issue_addr_i;
            cnt_d  = 2'd0;
        end
        if (match_o) begin
            buf_d[{cnt_q, 6'd0} +: BEAT_BITS] = rdata_i;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'(BEATS - 1)) begin
                resp_d = 1'b1;
                line_d = buf_d;
                cnt_d  = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            buf_q  <= '0;
            line_q <= '0;
            resp_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            buf_q  <= buf_d;
            line_q <= line_d;
            resp_q <= resp_d;
        end
    end

endmodule

// File: rtl/bmem_line_arbiter.sv
// Arbitrates icache/dcache line requests onto a 64-bit, 4-beat burst port;
// read bursts return out of order and are routed back by raddr tag.
//
// state       | meaning
// ISSUE_IDLE  | pick a requester; reads issue here, writes move to WRITE_BURST
// WRITE_BURST | stream dcache write line as 4 beats, beat advances on ready
module bmem_line_arbiter
    import bmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_read,
    output line_t       i_rdata,
    output logic        i_resp,
    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  line_t       d_wdata,
    output line_t       d_rdata,
    output logic        d_resp,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    output logic        bmem_write,
    output beat_t       bmem_wdata,
    input  logic        bmem_ready,
    input  logic [31:0] bmem_raddr,
    input  beat_t       bmem_rdata,
    input  logic        bmem_rvalid,
    output logic        err
);

    issue_state_t state_q, state_d;
    logic         rr_q, rr_d;          // 0: icache wins a tie, 1: dcache wins
    logic [1:0]   wcnt_q, wcnt_d;
    logic         wr_resp_q, wr_resp_d;
    logic         err_q, err_d;

    logic         i_pend, d_pend, i_match, d_match, i_rresp, d_rresp;
    logic [31:0]  i_paddr, d_paddr;
    logic         i_issue, d_issue, i_elig, d_elig;

    line_deserializer u_ides (
        .clk          (clk),
        .rst          (rst),
        .issue_i      (i_issue),
        .issue_addr_i (line_addr(i_addr)),
        .rvalid_i     (bmem_rvalid),
        .raddr_i      (bmem_raddr),
        .rdata_i      (bmem_rdata),
        .pend_o       (i_pend),
        .addr_o       (i_paddr),
        .match_o      (i_match),
        .line_o       (i_rdata),
        .resp_o       (i_rresp)
    );

    line_deserializer u_ddes (
        .clk          (clk),
        .rst          (rst),
        .issue_i      (d_issue),
        .issue_addr_i (line_addr(d_addr)),
        .rvalid_i     (bmem_rvalid),
        .raddr_i      (bmem_raddr),
        .rdata_i      (bmem_rdata),
        .pend_o       (d_pend),
        .addr_o       (d_paddr),
        .match_o      (d_match),
        .line_o       (d_rdata),
        .resp_o       (d_rresp)
    );

    // A read aliasing the other port's outstanding line waits so raddr stays unambiguous.
    assign i_elig = i_read && !i_pend && !(d_pend && (d_paddr == line_addr(i_addr)));
    assign d_elig = (d_read || d_write) && !d_pend && !wr_resp_q &&
                    (d_write || !(i_pend && (i_paddr == line_addr(d_addr))));

    assign i_resp = i_rresp;
    assign d_resp = d_rresp || wr_resp_q;
    assign err    = err_q;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        wcnt_d     = wcnt_q;
        wr_resp_d  = 1'b0;
        i_issue    = 1'b0;
        d_issue    = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        case (state_q)
            ISSUE_IDLE: begin
                if (i_elig && (!d_elig || !rr_q)) begin
                    bmem_read = 1'b1;
                    bmem_addr = line_addr(i_addr);
                    if (bmem_ready) begin
                        i_issue = 1'b1;
                        rr_d    = 1'b1;
                    end
                end else if (d_elig) begin
                    bmem_addr = line_addr(d_addr);
                    if (d_write) begin
                        state_d = WRITE_BURST;
                        wcnt_d  = 2'd0;
                        rr_d    = 1'b0;
                    end else begin
                        bmem_read = 1'b1;
                        if (bmem_ready) begin
                            d_issue = 1'b1;
                            rr_d    = 1'b0;
                        end
                    end
                end
            end
            WRITE_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = line_addr(d_addr);
                bmem_wdata = d_wdata[{wcnt_q, 6'd0} +: BEAT_BITS];
                if (bmem_ready) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'(BEATS - 1)) begin
                        state_d   = ISSUE_IDLE;
                        wr_resp_d = 1'b1;
                    end
                end
            end
            default: state_d = ISSUE_IDLE;
        endcase
        // Outputs must read 0 for the whole reset window, not just after it.
        if (rst) begin
            bmem_read  = 1'b0;
            bmem_write = 1'b0;
            bmem_addr  = '0;
            bmem_wdata = '0;
            i_issue    = 1'b0;
            d_issue    = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (bmem_rvalid && !i_match && !d_match)          err_d = 1'b1;
        if (d_read && d_write)                            err_d = 1'b1;
        if (i_pend && !i_rresp && !i_read)                err_d = 1'b1;
        if (d_pend && !d_rresp && !d_read)                err_d = 1'b1;
        if ((state_q == WRITE_BURST) && !d_write)         err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ISSUE_IDLE;
            rr_q      <= 1'b0;
            wcnt_q    <= '0;
            wr_resp_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            wcnt_q    <= wcnt_d;
            wr_resp_q <= wr_resp_d;
            err_q     <= err_d;
        end
    end

endmodule
